// File: rtl/johnson_decoder.sv
// Johnson-code decoder with sequence tracking.
//
// Handshake: in_valid qualifies jin for exactly the cycle it is high; there is
// no backpressure. Each sampled jin produces exactly one out_valid cycle on the
// following cycle, and all per-sample outputs are zero whenever out_valid is 0.
//
// A small FSM (SEARCH -> ACQUIRE -> LOCKED) follows the sampled codes and
// flags samples that are not the successor of the previous one. The current
// state is exposed on fsm_state for observation.
module johnson_decoder #(
    parameter  int WIDTH    = 4,
    parameter  int LOCK_CNT = 2,
    localparam int IDXW     = $clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   jin,
    input  logic               err_clr,
    output logic               out_valid,
    output logic [IDXW-1:0]    idx,
    output logic [2*WIDTH-1:0] onehot,
    output logic               code_err,
    output logic               seq_err,
    output logic               locked,
    output logic [7:0]         err_cnt,
    output logic [1:0]         fsm_state
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] ACQUIRE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(2 * WIDTH - 1);

    // Johnson code word for state index k: the first WIDTH steps fill ones in
    // from the MSB, the remaining steps drain them out from the MSB.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (k <= WIDTH) begin
                c[b] = (b >= WIDTH - k);
            end else begin
                c[b] = (b < 2 * WIDTH - k);
            end
        end
        return c;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [IDXW-1:0]    ref_q, ref_d;
    logic [3:0]         good_q, good_d;

    logic               dec_legal;
    logic [IDXW-1:0]    dec_idx;
    logic [IDXW-1:0]    succ_idx;
    logic               is_succ;

    logic               seq_err_d;
    logic [IDXW-1:0]    idx_d;
    logic [2*WIDTH-1:0] onehot_d;
    logic               code_err_d;
    logic               err_inc;

    // Map jin onto its state index; anything not in the table is illegal.
    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < 2 * WIDTH; k++) begin
            if (jin == code_of(k)) begin
                dec_legal = 1'b1;
                dec_idx   = IDXW'(k);
            end
        end
    end

    // Expected next index after the reference, wrapping to 0 after the last state.
    always_comb begin
        succ_idx = (ref_q == LAST_IDX) ? '0 : ref_q + 1'b1;
        is_succ  = dec_legal && (dec_idx == succ_idx);
    end

    // State, reference index and good-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            ref_q   <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            good_q  <= good_d;
        end
    end

    // Next-state logic; cycles without in_valid hold everything.
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        good_d    = good_q;
        seq_err_d = 1'b0;
        if (in_valid) begin
            case (state_q)
                SEARCH: begin
                    if (dec_legal) begin
                        state_d = ACQUIRE;
                        ref_d   = dec_idx;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (!dec_legal) begin
                        state_d = SEARCH;
                        good_d  = '0;
                    end else if (is_succ) begin
                        ref_d = dec_idx;
                        if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        seq_err_d = 1'b1;
                        ref_d     = dec_idx;
                        good_d    = '0;
                    end
                end
                LOCKED: begin
                    if (!dec_legal) begin
                        state_d = SEARCH;
                    end else if (is_succ) begin
                        ref_d = dec_idx;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = ACQUIRE;
                        ref_d     = dec_idx;
                        good_d    = '0;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    ref_d   = '0;
                    good_d  = '0;
                end
            endcase
        end
    end

    // Per-sample output values, zero unless a legal/illegal sample is present.
    always_comb begin
        idx_d      = '0;
        onehot_d   = '0;
        code_err_d = 1'b0;
        if (in_valid) begin
            if (dec_legal) begin
                idx_d            = dec_idx;
                onehot_d[dec_idx] = 1'b1;
            end else begin
                code_err_d = 1'b1;
            end
        end
        err_inc = in_valid && (state_q == LOCKED) && !is_succ;
    end

    // Output register: one-cycle latency, zeroed on reset so in-flight samples vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
            onehot    <= '0;
            code_err  <= 1'b0;
            seq_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            idx       <= idx_d;
            onehot    <= onehot_d;
            code_err  <= code_err_d;
            seq_err   <= in_valid && seq_err_d;
            if (err_clr) begin
                err_cnt <= '0;
            end else if (err_inc && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

    assign locked    = (state_q == LOCKED);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder (WIDTH=4, LOCK_CNT=2).
module tb_johnson_decoder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] jin;
    logic       err_clr;
    logic       out_valid;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       code_err;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_cnt;
    logic [1:0] fsm_state;

    int total = 0;
    int bad   = 0;

    johnson_decoder #(.WIDTH(4), .LOCK_CNT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .jin       (jin),
        .err_clr   (err_clr),
        .out_valid (out_valid),
        .idx       (idx),
        .onehot    (onehot),
        .code_err  (code_err),
        .seq_err   (seq_err),
        .locked    (locked),
        .err_cnt   (err_cnt),
        .fsm_state (fsm_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] j;
        logic       clr;
        logic       ov;
        logic [2:0] ix;
        logic [7:0] oh;
        logic       ce;
        logic       se;
        logic       lk;
        logic [7:0] ec;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then let the sample land.
    task automatic apply(input logic v, input logic [3:0] j, input logic clr);
        @(negedge clk);
        in_valid = v;
        jin      = j;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input int n, input vec_t e);
        string tag;
        tag = $sformatf("v%0d", n);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
        chk({tag, ".idx"},       32'(idx),       32'(e.ix));
        chk({tag, ".onehot"},    32'(onehot),    32'(e.oh));
        chk({tag, ".code_err"},  32'(code_err),  32'(e.ce));
        chk({tag, ".seq_err"},   32'(seq_err),   32'(e.se));
        chk({tag, ".locked"},    32'(locked),    32'(e.lk));
        chk({tag, ".err_cnt"},   32'(err_cnt),   32'(e.ec));
    endtask

    initial begin
        int exp_ec;

        //            v  jin      clr ov idx   onehot  ce se lk err_cnt
        vecs[0]  = '{1, 4'b0000, 0, 1, 3'd0, 8'h01, 0, 0, 0, 8'd0};  // SEARCH -> ACQUIRE
        vecs[1]  = '{1, 4'b1000, 0, 1, 3'd1, 8'h02, 0, 0, 0, 8'd0};
        vecs[2]  = '{1, 4'b1100, 0, 1, 3'd2, 8'h04, 0, 0, 1, 8'd0};  // lock
        vecs[3]  = '{1, 4'b1110, 0, 1, 3'd3, 8'h08, 0, 0, 1, 8'd0};
        vecs[4]  = '{1, 4'b1111, 0, 1, 3'd4, 8'h10, 0, 0, 1, 8'd0};
        vecs[5]  = '{1, 4'b0111, 0, 1, 3'd5, 8'h20, 0, 0, 1, 8'd0};
        vecs[6]  = '{1, 4'b0011, 0, 1, 3'd6, 8'h40, 0, 0, 1, 8'd0};
        vecs[7]  = '{1, 4'b0001, 0, 1, 3'd7, 8'h80, 0, 0, 1, 8'd0};
        vecs[8]  = '{1, 4'b0000, 0, 1, 3'd0, 8'h01, 0, 0, 1, 8'd0};  // wrap
        vecs[9]  = '{1, 4'b1000, 0, 1, 3'd1, 8'h02, 0, 0, 1, 8'd0};
        vecs[10] = '{0, 4'b1111, 0, 0, 3'd0, 8'h00, 0, 0, 1, 8'd0};  // idle cycle holds
        vecs[11] = '{1, 4'b1110, 0, 1, 3'd3, 8'h08, 0, 1, 0, 8'd1};  // skip
        vecs[12] = '{1, 4'b1111, 0, 1, 3'd4, 8'h10, 0, 0, 0, 8'd1};
        vecs[13] = '{1, 4'b0111, 0, 1, 3'd5, 8'h20, 0, 0, 1, 8'd1};  // relock
        vecs[14] = '{1, 4'b0111, 0, 1, 3'd5, 8'h20, 0, 1, 0, 8'd2};  // held code
        vecs[15] = '{1, 4'b0011, 0, 1, 3'd6, 8'h40, 0, 0, 0, 8'd2};
        vecs[16] = '{1, 4'b0001, 0, 1, 3'd7, 8'h80, 0, 0, 1, 8'd2};
        vecs[17] = '{1, 4'b0101, 0, 1, 3'd0, 8'h00, 1, 0, 0, 8'd3};  // illegal while locked
        vecs[18] = '{1, 4'b1001, 0, 1, 3'd0, 8'h00, 1, 0, 0, 8'd3};  // illegal in SEARCH
        vecs[19] = '{1, 4'b0000, 0, 1, 3'd0, 8'h01, 0, 0, 0, 8'd3};
        vecs[20] = '{1, 4'b0000, 0, 1, 3'd0, 8'h01, 0, 1, 0, 8'd3};  // held in ACQUIRE
        vecs[21] = '{1, 4'b1000, 0, 1, 3'd1, 8'h02, 0, 0, 0, 8'd3};
        vecs[22] = '{1, 4'b1100, 0, 1, 3'd2, 8'h04, 0, 0, 1, 8'd3};
        vecs[23] = '{1, 4'b0101, 1, 1, 3'd0, 8'h00, 1, 0, 0, 8'd0};  // clear beats increment
        vecs[24] = '{1, 4'b0000, 0, 1, 3'd0, 8'h01, 0, 0, 0, 8'd0};

        // Reset
        rst      = 1'b1;
        in_valid = 1'b0;
        jin      = 4'b0000;
        err_clr  = 1'b0;
        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.locked",    32'(locked),    32'd0);
        chk("rst.err_cnt",   32'(err_cnt),   32'd0);
        chk("rst.state",     32'(fsm_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle.out_valid", 32'(out_valid), 32'd0);

        // Table-driven main sequence
        for (int n = 0; n < 25; n++) begin
            apply(vecs[n].v, vecs[n].j, vecs[n].clr);
            chk_vec(n, vecs[n]);
            if (n == 17) chk("v17.state_search", 32'(fsm_state), 32'd0);
        end

        // Saturation: relock then take an illegal code, 300 times
        exp_ec = 0;
        for (int i = 0; i < 300; i++) begin
            apply(1'b1, 4'b0000, 1'b0);
            apply(1'b1, 4'b1000, 1'b0);
            apply(1'b1, 4'b1100, 1'b0);
            chk($sformatf("sat%0d.locked", i), 32'(locked), 32'd1);
            apply(1'b1, 4'b0101, 1'b0);
            exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
            chk($sformatf("sat%0d.err_cnt", i), 32'(err_cnt), 32'(exp_ec));
        end

        // Asynchronous reset with a sample in flight
        apply(1'b1, 4'b0000, 1'b0);
        apply(1'b1, 4'b1000, 1'b0);
        chk("pre_rst.out_valid", 32'(out_valid), 32'd1);
        chk("pre_rst.err_cnt",   32'(err_cnt),   32'd255);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.out_valid", 32'(out_valid), 32'd0);
        chk("async_rst.idx",       32'(idx),       32'd0);
        chk("async_rst.onehot",    32'(onehot),    32'd0);
        chk("async_rst.code_err",  32'(code_err),  32'd0);
        chk("async_rst.seq_err",   32'(seq_err),   32'd0);
        chk("async_rst.locked",    32'(locked),    32'd0);
        chk("async_rst.err_cnt",   32'(err_cnt),   32'd0);
        chk("async_rst.state",     32'(fsm_state), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.out_valid", 32'(out_valid), 32'd0);
        chk("post_rst.state",     32'(fsm_state), 32'd0);

        // First sample after reset decodes normally and enters ACQUIRE
        apply(1'b1, 4'b1100, 1'b0);
        chk("after.out_valid", 32'(out_valid), 32'd1);
        chk("after.idx",       32'(idx),       32'd2);
        chk("after.onehot",    32'(onehot),    32'h04);
        chk("after.locked",    32'(locked),    32'd0);
        chk("after.state",     32'(fsm_state), 32'd1);
        apply(1'b0, 4'b0000, 1'b0);
        chk("after.drop_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
